// File: rtl/dist4_pkg.sv
// Shared definitions for the dist4_reg 1-to-4 registered distributor.
package dist4_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] slot_idx_t;

  function automatic logic [NUM_SLOTS-1:0] sel_decode(input slot_idx_t sel);
    logic [NUM_SLOTS-1:0] onehot;
    onehot      = '0;
    onehot[sel] = 1'b1;
    return onehot;
  endfunction

endpackage

// File: rtl/dist_slot.sv
// Single-entry output slot: one register stage with valid/ready handshake.
module dist_slot #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [N-1:0] data_in,
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] data,
  output logic         free
);

  logic         valid_d, valid_q;
  logic [N-1:0] data_d,  data_q;

  // Load wins over drain, so a slot drained this cycle can be refilled without a bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign free  = !valid_q || ready;

endmodule

// File: rtl/dist4_reg.sv
// Registered 1-to-4 distributor: steers each accepted word into one of four slots.
// Optional broadcast to all slots is enabled by defining DIST4_BCAST_EN.
module dist4_reg
  import dist4_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DPFLAG = 0,
  parameter string       GROUP  = "std"
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [N-1:0]           IN_DATA,
  input  logic [SEL_W-1:0]       IN_SEL,
  input  logic                   IN_BCAST,
  output logic [NUM_SLOTS-1:0]   OUT_VALID,
  input  logic [NUM_SLOTS-1:0]   OUT_READY,
  output logic [NUM_SLOTS*N-1:0] OUT_DATA
);

  logic [NUM_SLOTS-1:0] free;
  logic [NUM_SLOTS-1:0] load;
  logic                 bcast;
  logic                 in_ready;

`ifndef DIST4_BCAST_EN
  logic unused_bcast;
  assign unused_bcast = IN_BCAST;
`endif

  always_comb begin
    bcast = 1'b0;
`ifdef DIST4_BCAST_EN
    bcast = IN_BCAST;
`endif
    in_ready = bcast ? (&free) : free[IN_SEL];
    load     = '0;
    if (IN_VALID && in_ready) begin
      load = bcast ? '1 : sel_decode(slot_idx_t'(IN_SEL));
    end
  end

  assign IN_READY = in_ready;

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    dist_slot #(.N(N)) u_slot (
      .clk     (CLK),
      .rst_n   (RSTN),
      .load    (load[k]),
      .data_in (IN_DATA),
      .ready   (OUT_READY[k]),
      .valid   (OUT_VALID[k]),
      .data    (OUT_DATA[k*N +: N]),
      .free    (free[k])
    );
  end

  if (DPFLAG != 0) begin : g_dp_warn
    $warning("(WARNING) The instance %m of type dist4_reg can't be implemented as a data-path cell");
  end

endmodule

// File: tb/tb_dist4_reg.sv
// Scoreboard bench for dist4_reg: per-slot expected queues filled on acceptance, drained by a monitor.
`timescale 1ns/1ps
module tb_dist4_reg;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_DATA;
  logic [1:0]  IN_SEL;
  logic        IN_BCAST;
  logic [3:0]  OUT_VALID;
  logic [3:0]  OUT_READY;
  logic [31:0] OUT_DATA;

  int compared   = 0;
  int mismatched = 0;

  dist4_reg #(.N(8), .DPFLAG(0), .GROUP("std")) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_SEL    (IN_SEL),
    .IN_BCAST  (IN_BCAST),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA)
  );

  always #10 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot occupancy plus per-slot queue of expected words.
  logic [3:0] mvalid = '0;
  logic [7:0] exp_q [4][$];

  function automatic logic model_bcast();
`ifdef DIST4_BCAST_EN
    return IN_BCAST;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic model_ready();
    logic [3:0] fr;
    fr = ~mvalid | OUT_READY;
    return model_bcast() ? (&fr) : fr[IN_SEL];
  endfunction

  always @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mvalid = '0;
      for (int k = 0; k < 4; k++) exp_q[k].delete();
    end else begin
      logic acc, bc;
      acc = IN_VALID && model_ready();
      bc  = model_bcast();
      for (int k = 0; k < 4; k++) begin
        if (acc && (bc || IN_SEL == 2'(k))) begin
          mvalid[k] = 1'b1;
          exp_q[k].push_back(IN_DATA);
        end else if (mvalid[k] && OUT_READY[k]) begin
          mvalid[k] = 1'b0;
        end
      end
    end
  end

  // Monitor: checks handshake outputs and pops a word whenever a slot hands off.
  logic [3:0] prev_hold = '0;
  logic [7:0] prev_data [4];

  always @(negedge CLK) begin
    if (RSTN) begin
      chk("in_ready", {31'd0, IN_READY}, {31'd0, model_ready()});
      chk("out_valid", {28'd0, OUT_VALID}, {28'd0, mvalid});
      for (int k = 0; k < 4; k++) begin
        if (prev_hold[k] && OUT_VALID[k])
          chk($sformatf("stable%0d", k), {24'd0, OUT_DATA[k*8 +: 8]}, {24'd0, prev_data[k]});
        if (mvalid[k] && OUT_READY[k]) begin
          if (exp_q[k].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL underflow%0d: got output %0h expected no word", k, OUT_DATA[k*8 +: 8]);
          end else begin
            chk($sformatf("slot%0d_data", k), {24'd0, OUT_DATA[k*8 +: 8]}, {24'd0, exp_q[k].pop_front()});
          end
        end
        prev_hold[k] = OUT_VALID[k] && !OUT_READY[k];
        prev_data[k] = OUT_DATA[k*8 +: 8];
      end
    end else begin
      prev_hold = '0;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic bc, input logic [3:0] rdy);
    IN_VALID  = v;
    IN_SEL    = sel;
    IN_DATA   = d;
    IN_BCAST  = bc;
    OUT_READY = rdy;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish by 5ms");
    $fatal(1, "timeout");
  end

  initial begin
    RSTN = 1'b0;
    drive(0, 2'd0, 8'h00, 0, 4'h0);
    #3;
    chk("rst_valid", {28'd0, OUT_VALID}, 32'h0);
    chk("rst_data", OUT_DATA, 32'h0);
    chk("rst_ready", {31'd0, IN_READY}, 32'h1);
    step();
    step();
    RSTN = 1'b1;

    // Single word to slot 1, no sink ready
    drive(1, 2'd1, 8'hA5, 0, 4'h0);
    step();
    IN_VALID = 1'b0;
    chk("single_valid", {28'd0, OUT_VALID}, 32'h2);
    chk("single_data", {24'd0, OUT_DATA[15:8]}, 32'hA5);
    IN_SEL = 2'd1;
    #1 chk("single_rdy_sel1", {31'd0, IN_READY}, 32'h0);
    IN_SEL = 2'd3;
    #1 chk("single_rdy_sel3", {31'd0, IN_READY}, 32'h1);
    step();
    OUT_READY = 4'hF;
    step();
    OUT_READY = 4'h0;

    // Stall then simultaneous drain and load on slot 0
    drive(1, 2'd0, 8'h11, 0, 4'h0);
    step();
    IN_VALID = 1'b0;
    step();
    chk("stall_data", {24'd0, OUT_DATA[7:0]}, 32'h11);
    drive(1, 2'd0, 8'h22, 0, 4'h1);
    #1 chk("dl_ready", {31'd0, IN_READY}, 32'h1);
    step();
    drive(0, 2'd0, 8'h00, 0, 4'h0);
    chk("dl_valid", {28'd0, OUT_VALID}, 32'h1);
    chk("dl_data", {24'd0, OUT_DATA[7:0]}, 32'h22);
    OUT_READY = 4'hF;
    step();

    // Round-robin stream of 1..16, every sink ready
    for (int i = 1; i <= 16; i++) begin
      drive(1, 2'(i % 4), 8'(i), 0, 4'hF);
      #1 chk("rr_ready", {31'd0, IN_READY}, 32'h1);
      step();
    end
    IN_VALID = 1'b0;
    step();
    chk("rr_drained", {28'd0, OUT_VALID}, 32'h0);

    // Broadcast against a stalled slot 3
    drive(1, 2'd3, 8'h77, 0, 4'h0);
    step();
    drive(1, 2'd0, 8'h3C, 1, 4'h0);
`ifdef DIST4_BCAST_EN
    #1 chk("bc_blocked", {31'd0, IN_READY}, 32'h0);
    step();
    chk("bc_still", {28'd0, OUT_VALID}, 32'h8);
    OUT_READY = 4'h8;
    #1 chk("bc_ready", {31'd0, IN_READY}, 32'h1);
    step();
    drive(0, 2'd0, 8'h00, 0, 4'h0);
    chk("bc_valid", {28'd0, OUT_VALID}, 32'hF);
    chk("bc_data", OUT_DATA, 32'h3C3C3C3C);
`else
    #1 chk("uc_ready", {31'd0, IN_READY}, 32'h1);
    step();
    drive(0, 2'd0, 8'h00, 0, 4'h0);
    chk("uc_valid", {28'd0, OUT_VALID}, 32'h9);
    chk("uc_data0", {24'd0, OUT_DATA[7:0]}, 32'h3C);
    chk("uc_data3", {24'd0, OUT_DATA[31:24]}, 32'h77);
`endif
    OUT_READY = 4'hF;
    step();
    step();
    OUT_READY = 4'h0;

    // Asynchronous reset mid-cycle with slot 2 full
    drive(1, 2'd2, 8'h5A, 0, 4'h0);
    step();
    IN_VALID = 1'b0;
    chk("pre_rst_valid", {28'd0, OUT_VALID}, 32'h4);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_valid", {28'd0, OUT_VALID}, 32'h0);
    chk("arst_data", OUT_DATA, 32'h0);
    for (int s = 0; s < 4; s++) begin
      IN_SEL = 2'(s);
      #1 chk("arst_ready", {31'd0, IN_READY}, 32'h1);
    end
    step();
    RSTN = 1'b1;

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
            ($urandom_range(0, 7) == 0), 4'($urandom));
      step();
    end
    drive(0, 2'd0, 8'h00, 0, 4'hF);
    step();
    step();
    chk("final_drained", {28'd0, OUT_VALID}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
